// File: rtl/cross_clk_cnt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cross_clk_cnt
//
// Purpose:
//   Counts inc pulses in the clk_a domain and republishes the running total in
//   the clk_b domain. The count crosses as Gray code through a SYNC_STAGES-deep
//   flop chain. Because consecutive counts differ in one Gray bit, cnt_b only
//   ever shows a value that cnt_a actually held.
//
// Parameters:
//   W           - counter width (default 8)
//   SYNC_STAGES - synchronizer depth in the clk_b domain (default 2, min 2)
//
// Ports:
//   clk_a  in  1  source-domain clock
//   rst_a  in  1  source-domain synchronous reset, active-high
//   clk_b  in  1  destination-domain clock
//   rst_b  in  1  destination-domain synchronous reset, active-high
//   inc    in  1  count enable, sampled on each rising clk_a edge
//   cnt_a  out W  binary count, clk_a domain (registered)
//   cnt_b  out W  binary count, clk_b domain (registered, delayed copy of cnt_a)
// -----------------------------------------------------------------------------
module cross_clk_cnt #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_a,
  input  logic         rst_a,
  input  logic         clk_b,
  input  logic         rst_b,
  input  logic         inc,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b
);

  // ---------------------------------------------------------------------------
  // Domain A: binary counter plus its Gray image
  // ---------------------------------------------------------------------------
  logic [W-1:0] r_cnt_a;
  logic [W-1:0] r_g_a;
  logic [W-1:0] w_cnt_a_next;
  logic [W-1:0] w_g_a_next;

  assign w_cnt_a_next = r_cnt_a + W'(1);
  // Gray is derived from the next binary value so r_g_a always encodes the
  // same count that r_cnt_a holds after the edge.
  assign w_g_a_next   = w_cnt_a_next ^ (w_cnt_a_next >> 1);

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      r_cnt_a <= '0;
      r_g_a   <= '0;
    end else if (inc) begin
      r_cnt_a <= w_cnt_a_next;
      r_g_a   <= w_g_a_next;
    end
  end

  assign cnt_a = r_cnt_a;

  // ---------------------------------------------------------------------------
  // Domain B: synchronizer chain. r_g_a feeds stage 0 directly with no logic
  // in between, so only one bit can be in flight at any capture.
  // ---------------------------------------------------------------------------
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][W-1:0] r_sync;

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], r_g_a};
    end
  end

  // Gray to binary: bit i is the XOR of all Gray bits at and above i.
  logic [W-1:0] w_sync_bin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_gray2bin
      assign w_sync_bin[gi] = ^(r_sync[SYNC_STAGES-1] >> gi);
    end
  endgenerate

  logic [W-1:0] r_cnt_b;

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      r_cnt_b <= '0;
    end else begin
      r_cnt_b <= w_sync_bin;
    end
  end

  assign cnt_b = r_cnt_b;

endmodule

// File: tb/tb_cross_clk_cnt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cross_clk_cnt
//
// Directed bench for cross_clk_cnt at default parameters (W=8, 2 stages).
// A reference count is kept from the inc/rst_a values seen at each clk_a edge,
// along with the set of values that count has held since the last reset.
// -----------------------------------------------------------------------------
module tb_cross_clk_cnt;

  logic       clk_a = 1'b0;
  logic       clk_b = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic       inc;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  real b_half = 4.5;   // clk_b half period, changed for the slow-destination run

  int checks = 0;
  int errors = 0;

  cross_clk_cnt #(.W(8), .SYNC_STAGES(2)) dut (
    .clk_a (clk_a),
    .rst_a (rst_a),
    .clk_b (clk_b),
    .rst_b (rst_b),
    .inc   (inc),
    .cnt_a (cnt_a),
    .cnt_b (cnt_b)
  );

  initial begin
    #2;
    forever #5 clk_a = ~clk_a;
  end

  initial forever #(b_half) clk_b = ~clk_b;

  // ---------------------------------------------------------------------------
  // Reference model: count and set of held values
  // ---------------------------------------------------------------------------
  logic [7:0] model_a = 8'd0;
  bit         seen [256];
  bit         sb_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk_a);
      if (rst_a) begin
        model_a = 8'd0;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[0] = 1'b1;
      end else if (inc) begin
        model_a = model_a + 8'd1;
        seen[model_a] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s actual=%0d required<=%0d at %0t", name, act, lim, $time);
    end
  endtask

  // Scoreboard: cnt_a must track the reference count on every clk_a cycle.
  initial begin
    forever begin
      @(negedge clk_a);
      if (sb_en) chk("sb_cnt_a", {24'd0, cnt_a}, {24'd0, model_a});
    end
  end

  // cnt_b monitor: held value, bounded step, bounded lag behind the source.
  bit         mon_en = 1'b0;
  int         mon_maxd = 2;
  int         mon_maxlag = 6;
  int         max_d_seen = 0;
  logic [7:0] prev_b;
  bit         prev_valid = 1'b0;

  initial begin
    logic [7:0] d;
    logic [7:0] lag;
    forever begin
      @(negedge clk_b);
      if (mon_en) begin
        if (prev_valid) begin
          d = cnt_b - prev_b;
          chk_le("mon_delta", int'(d), mon_maxd);
          if (int'(d) > max_d_seen) max_d_seen = int'(d);
        end
        chk("mon_held", {31'd0, seen[cnt_b]}, 32'd1);
        lag = model_a - cnt_b;
        chk_le("mon_lag", int'(lag), mon_maxlag);
        prev_b     = cnt_b;
        prev_valid = 1'b1;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // Waits up to n clk_b edges for cnt_b to reach exp; one comparison.
  task automatic wait_b(input string name, input logic [7:0] exp, input int n);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < n && !ok; k++) begin
      @(posedge clk_b);
      #1;
      if (cnt_b === exp) ok = 1'b1;
    end
    chk(name, {24'd0, cnt_b}, {24'd0, exp});
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk_a);
    rst_a = 1'b1;
    inc   = 1'b0;
    @(negedge clk_b);
    rst_b = 1'b1;
    repeat (3) @(negedge clk_b);
    rst_b = 1'b0;
    repeat (3) @(negedge clk_a);
    rst_a = 1'b0;
    repeat (4) @(negedge clk_b);
    chk("reset_cnt_a", {24'd0, cnt_a}, 32'd0);
    chk("reset_cnt_b", {24'd0, cnt_b}, 32'd0);
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Single-increment vectors: inc for one clk_a cycle, expected cnt_a after it
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       inc;
    logic [7:0] exp_a;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] prev_a;
    bit         saw_wrap;

    vecs[0] = '{1'b1, 8'd1};
    vecs[1] = '{1'b0, 8'd1};
    vecs[2] = '{1'b1, 8'd2};
    vecs[3] = '{1'b0, 8'd2};
    vecs[4] = '{1'b1, 8'd3};
    vecs[5] = '{1'b1, 8'd4};
    vecs[6] = '{1'b0, 8'd4};
    vecs[7] = '{1'b0, 8'd4};
    vecs[8] = '{1'b1, 8'd5};
    vecs[9] = '{1'b0, 8'd5};

    // Reset with inc held high: both counts stay at zero
    rst_a = 1'b1;
    rst_b = 1'b1;
    inc   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_a);
      chk("rst_hold_cnt_a", {24'd0, cnt_a}, 32'd0);
      @(negedge clk_b);
      chk("rst_hold_cnt_b", {24'd0, cnt_b}, 32'd0);
    end
    @(negedge clk_b);
    rst_b = 1'b0;
    @(negedge clk_a);
    rst_a = 1'b0;
    inc   = 1'b0;
    sb_en = 1'b1;
    $display("reset phase: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

    // Isolated pulses
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_a);
      inc = vecs[i].inc;
      @(posedge clk_a);
      #1;
      chk("single_cnt_a", {24'd0, cnt_a}, {24'd0, vecs[i].exp_a});
      inc = 1'b0;
      if (vecs[i].inc) wait_b("single_cnt_b", vecs[i].exp_a, 4);
      $display("vec %0d: inc=%0b cnt_a=%0d cnt_b=%0d exp=%0d",
               i, vecs[i].inc, cnt_a, cnt_b, vecs[i].exp_a);
    end

    // Continuous count through the wrap
    do_reset();
    mon_maxd   = 2;
    mon_maxlag = 6;
    saw_wrap   = 1'b0;
    prev_a     = cnt_a;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk_a);
      if (prev_a == 8'd255 && cnt_a == 8'd0) saw_wrap = 1'b1;
      prev_a = cnt_a;
      inc    = 1'b1;
    end
    @(negedge clk_a);
    inc = 1'b0;
    @(negedge clk_a);
    chk("wrap_cnt_a", {24'd0, cnt_a}, 32'd4);
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);
    wait_b("wrap_cnt_b", 8'd4, 6);
    $display("wrap run: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

    // Long random run
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_a);
      inc = 1'($urandom_range(0, 1));
    end
    @(negedge clk_a);
    inc = 1'b0;
    @(negedge clk_a);
    chk("random_cnt_a", {24'd0, cnt_a}, {24'd0, model_a});
    wait_b("random_cnt_b", model_a, 6);
    $display("random run: cnt_a=%0d cnt_b=%0d model=%0d", cnt_a, cnt_b, model_a);

    // Slow destination clock: cnt_b must skip but stay monotonic
    mon_en     = 1'b0;
    b_half     = 18.5;
    mon_maxd   = 4;
    mon_maxlag = 20;
    repeat (2) @(negedge clk_b);
    max_d_seen = 0;
    mon_en     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_a);
      inc = 1'b1;
    end
    @(negedge clk_a);
    inc = 1'b0;
    @(negedge clk_a);
    chk("slow_cnt_a", {24'd0, cnt_a}, {24'd0, model_a});
    wait_b("slow_cnt_b", model_a, 6);
    chk("slow_skip", {31'd0, (max_d_seen > 1)}, 32'd1);
    $display("slow run: cnt_a=%0d cnt_b=%0d max_step=%0d", cnt_a, cnt_b, max_d_seen);
    mon_en     = 1'b0;
    b_half     = 4.5;
    repeat (2) @(negedge clk_b);
    mon_maxd   = 2;
    mon_maxlag = 6;

    // Mid-run rst_b with cnt_a at 100
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_a);
      inc = 1'b1;
    end
    @(negedge clk_a);
    inc = 1'b0;
    @(negedge clk_a);
    chk("rstb_pre_cnt_a", {24'd0, cnt_a}, 32'd100);
    wait_b("rstb_pre_cnt_b", 8'd100, 6);
    mon_en = 1'b0;
    @(negedge clk_b);
    rst_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_b);
      chk("rstb_hold_cnt_b", {24'd0, cnt_b}, 32'd0);
    end
    rst_b = 1'b0;
    wait_b("rstb_reacquire", 8'd100, 4);
    chk("rstb_cnt_a", {24'd0, cnt_a}, 32'd100);
    $display("rst_b run: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
